// File: rtl/temporal_bundler.sv
// Temporal bundler: per-bit majority vote over WINDOW consecutive hypervectors.
// Optional macro BUNDLER_FLUSH_EN adds a flush port that emits a partial bundle early.
module temporal_bundler #(
  parameter int DIMENSIONS = 10000,
  parameter int WINDOW     = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DIMENSIONS-1:0] in_hv,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DIMENSIONS-1:0] out_hv,
  output logic                  out_valid,
  input  logic                  out_ready
`ifdef BUNDLER_FLUSH_EN
  ,
  input  logic                  flush
`endif
);

  localparam int CW = $clog2(WINDOW + 1);

  typedef enum logic {
    ACCUM = 1'b0,
    EMIT  = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [CW-1:0]         r_n;
  logic [CW-1:0]         w_n_next;
  logic [DIMENSIONS-1:0] r_out_hv;
  logic [DIMENSIONS-1:0] w_majority;
  logic [DIMENSIONS-1:0] w_tie_hv;
  logic                  w_in_xfer;
  logic                  w_out_xfer;
  logic                  w_full;
  logic                  w_flush_go;
  logic                  w_capture;

  assign in_ready   = (r_state == ACCUM);
  assign out_valid  = (r_state == EMIT);
  assign out_hv     = r_out_hv;
  assign w_in_xfer  = in_valid && in_ready;
  assign w_out_xfer = out_valid && out_ready;
  assign w_n_next   = r_n + CW'(w_in_xfer);
  assign w_full     = w_in_xfer && (w_n_next == CW'(WINDOW));

`ifdef BUNDLER_FLUSH_EN
  logic [DIMENSIONS-1:0] r_last_hv;

  // Ties resolve to the most recent accepted sample, which may be this cycle's.
  assign w_flush_go = flush && in_ready && (w_n_next != '0);
  assign w_tie_hv   = w_in_xfer ? in_hv : r_last_hv;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_hv <= '0;
    end else if (w_in_xfer) begin
      r_last_hv <= in_hv;
    end
  end
`else
  assign w_flush_go = 1'b0;
  assign w_tie_hv   = in_hv;
`endif

  assign w_capture = w_full || w_flush_go;

  for (genvar g = 0; g < DIMENSIONS; g++) begin : g_bit
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_next;
    logic [CW:0]   w_twice;
    logic [CW:0]   w_total;

    assign w_cnt_next = r_cnt + CW'(w_in_xfer && in_hv[g]);
    assign w_twice    = {w_cnt_next, 1'b0};
    assign w_total    = {1'b0, w_n_next};
    assign w_majority[g] = (w_twice > w_total) ? 1'b1 :
                           (w_twice < w_total) ? 1'b0 : w_tie_hv[g];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_cnt <= '0;
      end else if (w_out_xfer) begin
        r_cnt <= '0;
      end else if (w_in_xfer) begin
        r_cnt <= w_cnt_next;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_n <= '0;
    end else if (w_out_xfer) begin
      r_n <= '0;
    end else if (w_in_xfer) begin
      r_n <= w_n_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_hv <= '0;
    end else if (w_capture) begin
      r_out_hv <= w_majority;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ACCUM;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ACCUM:   if (w_capture) w_state_next = EMIT;
      EMIT:    if (w_out_xfer) w_state_next = ACCUM;
      default: w_state_next = ACCUM;
    endcase
  end

endmodule

// File: doc/temporal_bundler.md
TEMPORAL_BUNDLER -- requirements
Module: temporal_bundler

Interface
REQ-001 Parameter DIMENSIONS, default 10000, hypervector width in bits.
REQ-002 Parameter WINDOW, default 8, number of input hypervectors bundled per output; legal range 1..255.
REQ-003 Port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1, reset: asynchronous assert, active-low.
REQ-005 Port in_hv, input, DIMENSIONS, encoded hypervector for one time step.
REQ-006 Port in_valid, input, 1, in_hv is valid this cycle.
REQ-007 Port in_ready, output, 1, block can accept in_hv this cycle.
REQ-008 Port out_hv, output, DIMENSIONS, bundled query hypervector for the downstream similarity stage.
REQ-009 Port out_valid, output, 1, out_hv is valid and held.
REQ-010 Port out_ready, input, 1, consumer accepts out_hv this cycle.
REQ-011 Port flush, input, 1, present only under BUNDLER_FLUSH_EN; emit the partial bundle early.

Function
REQ-012 Two states: ACCUM and EMIT; reset state ACCUM.
REQ-013 Input transfer occurs on a cycle with in_valid=1 and in_ready=1; output transfer occurs on a cycle with out_valid=1 and out_ready=1.
REQ-014 in_ready = 1 exactly in ACCUM; out_valid = 1 exactly in EMIT.
REQ-015 Per-bit counters cnt[i], width clog2(WINDOW+1), and sample counter n, same width; an input transfer adds in_hv[i] to cnt[i] and increments n.
REQ-016 On the input transfer that makes n = WINDOW: register out_hv, then enter EMIT on the next cycle; out_valid rises one cycle after the last transfer.
REQ-017 Majority rule, using n including the current transfer: out_hv[i] = 1 if 2*cnt[i] > n; 0 if 2*cnt[i] < n; tie (2*cnt[i] = n) takes in_hv[i] of the last accepted sample.
REQ-018 In EMIT, out_hv and out_valid are held stable until the output transfer; in_valid is ignored.
REQ-019 On the output transfer: clear all cnt[i] and n, return to ACCUM; in_ready = 1 on the following cycle. No input transfer occurs in that same cycle.
REQ-020 Counters never overflow: n is bounded by WINDOW through the state machine; no saturation logic.
REQ-021 WINDOW = 1: out_hv equals the single accepted in_hv.

Reset
REQ-022 rst_n = 0 forces, asynchronously: state ACCUM, all cnt[i] = 0, n = 0, out_hv = 0, out_valid = 0; in_ready = 1 once reset is asserted.
REQ-023 Reset during ACCUM or EMIT discards the partial or pending bundle; after release, the first input transfer starts a fresh window.

Configuration
REQ-024 Macro BUNDLER_FLUSH_EN: when defined, the flush port exists. In ACCUM with flush = 1 and n_eff ≥ 1, where n_eff = n plus 1 if an input transfer occurs that cycle, the block applies REQ-017 with n = n_eff and enters EMIT. The tie reference is the last accepted sample, including a same-cycle transfer.
REQ-025 With BUNDLER_FLUSH_EN defined, flush with n_eff = 0 is ignored, and flush in EMIT is ignored.
REQ-026 Without BUNDLER_FLUSH_EN: no flush port, and output occurs only at n = WINDOW.

Verification (DIMENSIONS=8, WINDOW=3 unless stated)
REQ-027 Inputs 8'hF0, 8'hCC, 8'hAA on consecutive cycles with out_ready=1 -> out_valid one cycle after the 3rd transfer, out_hv = 8'hE8; in_ready=0 during EMIT, then 1 next cycle.
REQ-028 WINDOW=2, inputs 8'hFF then 8'h0F -> all bits tie except [3:0]; out_hv = 8'h0F (last sample).
REQ-029 Bundle complete with out_ready=0 for 5 cycles while in_valid=1 and in_hv toggles -> out_hv stable, out_valid=1, no input accepted, cnt unchanged; release out_ready -> one transfer only.
REQ-030 Two inputs accepted, then rst_n pulsed low mid-cycle -> out_valid=0 and in_ready=1 immediately; next three inputs 8'h01 x3 -> out_hv = 8'h01.
REQ-031 BUNDLER_FLUSH_EN, WINDOW=8: flush asserted concurrently with the 2nd transfer (8'hF0 then 8'h3C) -> n_eff=2, out_hv = 8'h3C. flush with n=0 -> no out_valid.
